// File: rtl/i2d_core_defines.sv
// Shared core type definitions: load/store unit opcodes, access sizes and response tag.
package i2d_core_defines;

    typedef enum logic {
        LSUOP_R = 1'b0,
        LSUOP_W = 1'b1
    } lsu_op_t;

    typedef enum logic [1:0] {
        LSU_B = 2'd0,
        LSU_H = 2'd1,
        LSU_W = 2'd2,
        LSU_D = 2'd3
    } lsu_size_t;

    localparam int unsigned LSU_OFF_W = 3;

    typedef struct packed {
        lsu_op_t                op;
        lsu_size_t              size;
        logic                   sgn;
        logic [LSU_OFF_W-1:0]   off;
    } lsu_tag_t;

    // Mask a right-aligned load to its access size and zero- or sign-extend it.
    function automatic logic [63:0] lsu_extend(input logic [63:0] d, input lsu_size_t sz,
                                               input logic sgn);
        logic [63:0] r;
        r = d;
        case (sz)
            LSU_B:   r = sgn ? {{56{d[7]}}, d[7:0]}   : {56'd0, d[7:0]};
            LSU_H:   r = sgn ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
            LSU_W:   r = sgn ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wishbone.sv
// Pipelined Wishbone bus bundle with master and slave views.
interface wishbone #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_mo;
    logic [DW-1:0]   dat_so;
    logic            ack;
    logic            err;
    logic            stall;

    modport pl_master (output cyc, stb, we, sel, adr, dat_mo,
                       input  dat_so, ack, err, stall);
    modport pl_slave  (input  cyc, stb, we, sel, adr, dat_mo,
                       output dat_so, ack, err, stall);
endinterface

// File: rtl/core_lsu_tagfifo.sv
// Circular FIFO holding the response tags of issued, not yet acknowledged bus requests.
module core_lsu_tagfifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TW    = 7
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [TW-1:0]                wdata_i,
    output logic [TW-1:0]                rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [TW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they were written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;
endmodule

// File: rtl/core_lsu.sv
// Load/store unit: turns core load/store requests into pipelined Wishbone cycles
// and returns in-order, aligned and extended responses.
module core_lsu
    import i2d_core_defines::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  lsu_op_t        req_op,
    input  lsu_size_t      req_size,
    input  logic           req_signed,
    input  logic [AW-1:0]  req_addr,
    input  logic [DW-1:0]  req_wdata,
    output logic           rsp_valid,
    output logic [DW-1:0]  rsp_data,
    output logic           rsp_err,
    output logic           lsu_busy,
    wishbone.pl_master     bus
);
    localparam int unsigned SW   = DW/8;
    localparam int unsigned OFFW = $clog2(SW);
    localparam int unsigned CW   = $clog2(DEPTH+1);
    localparam int unsigned OW   = CW + 1;
    localparam int unsigned TW   = $bits(lsu_tag_t);

    logic            stb_q, stb_d, we_q, we_d, cyc_q, cyc_d;
    logic [SW-1:0]   sel_q, sel_d, sel_c;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_mo_q, dat_mo_d;
    lsu_tag_t        tag_q, tag_d, tag_c, head_c;
    logic            mis_pend_q, mis_pend_d, mis_c;
    logic            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d, ld_shift_c, ld_c;
    logic [OFFW-1:0] req_off, head_off;
    logic [TW-1:0]   fifo_rdata;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   count, cnt_nxt_c;
    logic            accept_c, issue_c, pop_c;

    assign req_off  = req_addr[OFFW-1:0];
    assign head_c   = lsu_tag_t'(fifo_rdata);
    assign head_off = OFFW'(head_c.off);

    // Request decode: alignment check, byte-lane select and tag to carry with the cycle.
    always_comb begin
        mis_c = 1'b0;
        sel_c = '0;
        case (req_size)
            LSU_B: sel_c = SW'(1) << req_off;
            LSU_H: begin
                mis_c = req_addr[0];
                sel_c = SW'(3) << req_off;
            end
            LSU_W: begin
                mis_c = (req_addr[1:0] != 2'b00);
                sel_c = SW'(4'hF) << req_off;
            end
            default: begin
                mis_c = (DW != 64) || (req_addr[2:0] != 3'b000);
                sel_c = '1;
            end
        endcase
        tag_c.op   = req_op;
        tag_c.size = req_size;
        tag_c.sgn  = req_signed;
        tag_c.off  = LSU_OFF_W'(req_off);
    end

    // The registered stb counts against DEPTH so the FIFO can never overflow.
    assign req_ready = ((OW'(count) + OW'(stb_q)) < OW'(DEPTH)) && !fifo_full
                       && !(stb_q && bus.stall) && !mis_pend_q
                       && (!mis_c || (count == '0 && !stb_q));
    assign accept_c  = req_valid && req_ready;
    assign issue_c   = stb_q && !bus.stall;
    assign pop_c     = (bus.ack || bus.err) && !fifo_empty;
    assign cnt_nxt_c = count + CW'(issue_c) - CW'(pop_c);

    assign ld_shift_c = bus.dat_so >> {head_off, 3'b000};
    assign ld_c       = DW'(lsu_extend(64'(ld_shift_c), head_c.size, head_c.sgn));

    always_comb begin
        stb_d    = stb_q;
        we_d     = we_q;
        sel_d    = sel_q;
        adr_d    = adr_q;
        dat_mo_d = dat_mo_q;
        tag_d    = tag_q;
        if (!(stb_q && bus.stall)) begin
            stb_d = accept_c && !mis_c;
            if (accept_c && !mis_c) begin
                we_d     = (req_op == LSUOP_W);
                sel_d    = sel_c;
                adr_d    = req_addr;
                dat_mo_d = (req_op == LSUOP_W) ? (req_wdata << {req_off, 3'b000}) : '0;
                tag_d    = tag_c;
            end
        end
        mis_pend_d  = accept_c && mis_c;
        cyc_d       = stb_d || (cnt_nxt_c != '0);
        rsp_valid_d = pop_c || mis_pend_q;
        rsp_err_d   = mis_pend_q || (pop_c && bus.err);
        rsp_data_d  = '0;
        if (pop_c && !bus.err && head_c.op == LSUOP_R) rsp_data_d = ld_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_mo_q    <= '0;
            tag_q       <= '0;
            mis_pend_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            stb_q       <= stb_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_mo_q    <= dat_mo_d;
            tag_q       <= tag_d;
            mis_pend_q  <= mis_pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    core_lsu_tagfifo #(.DEPTH(DEPTH), .TW(TW)) u_tagfifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (issue_c),
        .pop_i   (pop_c),
        .wdata_i (tag_q),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    assign bus.cyc    = cyc_q;
    assign bus.stb    = stb_q;
    assign bus.we     = we_q;
    assign bus.sel    = sel_q;
    assign bus.adr    = adr_q;
    assign bus.dat_mo = dat_mo_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_data   = rsp_data_q;
    assign lsu_busy   = stb_q || (count != '0);
endmodule

// File: doc/core_lsu.md
CORE_LSU -- requirements
Module: core_lsu

Interface
REQ-001 Parameter DW, 32, data bus width in bits; legal values 32 and 64.
REQ-002 Parameter AW, 32, address width in bits.
REQ-003 Parameter DEPTH, 2, maximum outstanding bus requests; legal values 1..4.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted this cycle when req_valid is also high.
REQ-008 req_op  input  lsu_op_t  LSUOP_R (load) or LSUOP_W (store).
REQ-009 req_size  input  lsu_size_t  B/H/W/D; D is legal only when DW=64.
REQ-010 req_signed  input  1  sign-extend load result.
REQ-011 req_addr  input  AW  byte address.
REQ-012 req_wdata  input  DW  store data, right-aligned.
REQ-013 rsp_valid  output  1  one-cycle response pulse, in request order.
REQ-014 rsp_data  output  DW  load data, aligned and extended; 0 for stores and errors.
REQ-015 rsp_err  output  1  bus error or misalignment, valid with rsp_valid.
REQ-016 lsu_busy  output  1  high while stb is high or the outstanding count is nonzero.
REQ-017 bus  wishbone.pl_master  --  pipelined Wishbone master: cyc, stb, we, sel, adr, dat_mo, dat_so, ack, err, stall.

Function
REQ-018 req_ready = (count<DEPTH) && !(bus.stb && bus.stall) && !mis_pend.
REQ-019 An accepted aligned request registers bus.stb=1, adr, we, sel and dat_mo in the next cycle; these are held unchanged while stall=1 and are released on the first cycle with stall=0.
REQ-020 Back-to-back accepts issue stb on consecutive cycles; stb drops when no request is pending.
REQ-021 Lane offset off = addr[log2(DW/8)-1:0]; sel = B:1<<off, H:3<<off, W:4'hF<<off, D:all ones.
REQ-022 Store dat_mo = req_wdata shifted left by 8*off; loads drive dat_mo=0.
REQ-023 Misalignment: H with addr[0]=1; W with addr[1:0]!=0; D with addr[2:0]!=0. A misaligned request issues no bus cycle.
REQ-024 A misaligned request is accepted only when count=0 and stb=0; it sets mis_pend, and the next cycle gives rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-025 Each issued request (stb && !stall) pushes {op, size, signed, off} into the tag FIFO; count increments.
REQ-026 ack or err pops the tag FIFO and decrements count; issue and pop in the same cycle leave count unchanged.
REQ-027 rsp_valid is registered, one cycle after ack/err.
REQ-028 Load rsp_data = (dat_so >> 8*off) masked to the size, then zero-extended, or sign-extended from bit 7/15/31 when req_signed=1.
REQ-029 err gives rsp_err=1 and rsp_data=0; the transaction is retired and later transactions continue.
REQ-030 ack or err with count=0 is ignored; no response is produced.
REQ-031 bus.cyc rises with the first stb and stays high while stb is high or count>0; it falls the cycle after the last ack/err when no new request is accepted.
REQ-032 There is no response backpressure; the consumer samples rsp_* every cycle.

Reset
REQ-033 While rst=0: cyc=0, stb=0, we=0, sel=0, adr=0, dat_mo=0, rsp_valid=0, rsp_err=0, rsp_data=0, count=0, FIFO empty, mis_pend=0, lsu_busy=0; req_ready is then 1 by REQ-018.
REQ-034 Reset during an operation discards all outstanding transactions; no response is produced for them.

Structure
REQ-035 lsu_op_t and lsu_size_t (B=0, H=1, W=2, D=3) live in the shared i2d_core_defines package alongside the existing MAU types.
REQ-036 The tag FIFO is the sub-module core_lsu_tagfifo, parametrised by DEPTH and tag width, with full/empty flags and pointer wrap.

Verification
REQ-037 DW=32, LW 0x100, dat_so=0x11223344, ack after 1 cycle -> sel=4'hF, adr=0x100; rsp_data=0x11223344, rsp_err=0, cyc low the following cycle.
REQ-038 LB signed 0x103, dat_so=0x80000000 -> sel=4'b1000; rsp_data=0xFFFFFF80. Same access unsigned -> 0x00000080.
REQ-039 SH 0x102, wdata=0xABCD -> sel=4'b1100, dat_mo=0xABCD0000, we=1; rsp_data=0 on ack.
REQ-040 DEPTH=2: three back-to-back loads with ack withheld -> req_ready=0 after two issues; acks release the third; three responses in order.
REQ-041 stall held 3 cycles -> stb/adr stable for all 3; a single push into the tag FIFO.
REQ-042 Misaligned LW 0x101 -> no stb, rsp_err=1 next cycle. A bus err on an outstanding load -> rsp_err=1, rsp_data=0. rst asserted mid-transaction -> all outputs at reset values, no late rsp_valid.
